i2c_cmd_arbiter: RTL and testbench
==================================

I2C_CMD_ARBITER -- requirements
Module: i2c_cmd_arbiter

Interface
REQ-001 Parameters SHALL be:
- WR_BITS, default 1: write payload bytes.
- RD_BITS, default 1: read payload bytes.
- TIMEOUT_CYC, default 200000: max clk cycles allowed in WAIT.

REQ-002 Ports SHALL be as follows; N = 0,1, one identical set per requester; width "W" = WR_BITS*8, "R" = RD_BITS*8.
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- reqN_valid  in  1  requester N has a command.
- reqN_ready  out  1  one-cycle pulse: command N accepted.
- reqN_rh_wl  in  1  1 = read, 0 = write.
- reqN_addr  in  16  I2C register address.
- reqN_wdata  in  W  write payload.
- reqN_rdata  out  R  read payload; valid while reqN_done = 1.
- reqN_done  out  1  one-cycle pulse: command N finished.
- reqN_err  out  1  NACK or timeout; valid while reqN_done = 1.
- m_wvalid  out  1  command valid to the I2C master.
- m_wready  in  1  master accepts the command.
- m_rh_wl  out  1  latched read/write flag.
- m_addr  out  16  latched address.
- m_wdata  out  W  latched write payload.
- m_rdata  in  R  master read data.
- m_rvalid  in  1  m_rdata valid.
- m_done  in  1  transfer-complete pulse.
- m_ack  in  1  1 = slave NACK seen during the transfer.
- m_busy  in  1  master is busy.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RESP.
REQ-004 IDLE: when m_busy = 0 and at least one reqN_valid = 1, the block SHALL grant one requester, latch its rh_wl/addr/wdata into m_*, pulse its reqN_ready for exactly that cycle, and go to ISSUE.
REQ-005 Arbitration SHALL be round-robin: if both are valid, grant the requester not granted last; last_grant resets to 1, so requester 0 wins the first tie.
REQ-006 IDLE while m_busy = 1: no grant and no reqN_ready.
REQ-007 ISSUE: m_wvalid SHALL be 1 and m_* SHALL stay stable until the cycle m_wready = 1, then go to WAIT; m_wvalid is 0 in every other state.
REQ-008 WAIT: a cycle counter SHALL increment each cycle from 0. On m_rvalid = 1, capture m_rdata into the response register.
REQ-009 WAIT: on m_done = 1, set err = m_ack and go to RESP. If the counter reaches TIMEOUT_CYC-1 without m_done, set err = 1 and go to RESP. If both happen in the same cycle, m_done takes priority.
REQ-010 RESP, one cycle: pulse reqN_done for the granted N only; drive reqN_rdata/reqN_err from the response registers; update last_grant; return to IDLE. The next grant is possible no earlier than the following cycle.
REQ-011 On a write, or a read with no m_rvalid, rdata SHALL be all-zero; the response register clears at each grant.
REQ-012 reqN_valid changes after acceptance SHALL have no effect until the next IDLE evaluation; inputs are sampled only in IDLE.
REQ-013 The non-granted requester's ready/done/err SHALL stay 0 throughout a transfer.
REQ-014 m_done or m_rvalid arriving outside WAIT SHALL be ignored.
REQ-015 Minimum latency, accept to done: grant cycle + 1 ISSUE cycle (m_wready already 1) + WAIT cycles + 1 RESP cycle.

Reset
REQ-016 While rst_n = 0 (asynchronous, active-low): state = IDLE; counter, response and latched registers = 0; last_grant = 1; all outputs = 0.
REQ-017 Reset asserted mid-transfer SHALL abort with no reqN_done pulse. After release, the block SHALL wait in IDLE for m_busy = 0 before granting.

Verification
REQ-018 Single write: req0 with addr=16'h0010, wdata=8'hA5, m_wready=1, m_done 20 cycles later with m_ack=0 -> m_addr=0010, m_wdata=A5, req0_done pulse, req0_err=0, req0_rdata=00.
REQ-019 Read: req1 rh_wl=1, m_rvalid with m_rdata=8'h3C, then m_done -> req1_done pulse, req1_rdata=3C, req1_err=0, req0 outputs all 0.
REQ-020 Contention: both valid continuously for 4 transfers -> grant order 0,1,0,1; each ready pulse exactly 1 cycle.
REQ-021 NACK and timeout: m_done with m_ack=1 -> err=1. With TIMEOUT_CYC=16 and no m_done -> done pulse on WAIT cycle 16, err=1.
REQ-022 Busy/reset: m_busy=1 with req0_valid -> no ready until m_busy=0. rst_n=0 during WAIT -> all outputs 0 immediately, no done pulse afterwards.

Source files
------------

// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter
//   Arbitrates two command requesters onto one I2C master command port.
//   A command is granted in IDLE, presented to the master in ISSUE, tracked
//   in WAIT (with a timeout) and answered to the requester in RESP.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   reqN_valid        requester N has a command (N = 0, 1)
//   reqN_ready        one-cycle accept pulse for requester N
//   reqN_rh_wl        1 = read, 0 = write
//   reqN_addr         16-bit I2C register address
//   reqN_wdata        write payload (WR_BITS bytes)
//   reqN_rdata        read payload, valid while reqN_done = 1
//   reqN_done         one-cycle completion pulse for requester N
//   reqN_err          NACK or timeout, valid while reqN_done = 1
//   m_wvalid/m_wready command handshake toward the I2C master
//   m_rh_wl, m_addr, m_wdata  latched command fields
//   m_rdata, m_rvalid read data from the master
//   m_done, m_ack     transfer complete pulse, NACK flag (1 = NACK)
//   m_busy            master busy; blocks new grants
//
// Handshake: reqN_valid is sampled only in IDLE; the cycle reqN_ready is
// high the command has been taken and the requester may change its inputs.
// Toward the master, m_wvalid stays high with stable m_* until the cycle
// m_wready is high.
module i2c_cmd_arbiter #(
  parameter int WR_BITS     = 1,
  parameter int RD_BITS     = 1,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_rh_wl,
  input  logic [15:0]          req0_addr,
  input  logic [WR_BITS*8-1:0] req0_wdata,
  output logic [RD_BITS*8-1:0] req0_rdata,
  output logic                 req0_done,
  output logic                 req0_err,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_rh_wl,
  input  logic [15:0]          req1_addr,
  input  logic [WR_BITS*8-1:0] req1_wdata,
  output logic [RD_BITS*8-1:0] req1_rdata,
  output logic                 req1_done,
  output logic                 req1_err,
  output logic                 m_wvalid,
  input  logic                 m_wready,
  output logic                 m_rh_wl,
  output logic [15:0]          m_addr,
  output logic [WR_BITS*8-1:0] m_wdata,
  input  logic [RD_BITS*8-1:0] m_rdata,
  input  logic                 m_rvalid,
  input  logic                 m_done,
  input  logic                 m_ack,
  input  logic                 m_busy
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                 state;
  logic                   grant;       // 1 = requester 1 owns the transfer
  logic                   last_grant;  // requester served by the last transfer
  logic [CW-1:0]          cnt;
  logic [RD_BITS*8-1:0]   resp_data;

  logic                   pick1;
  logic                   finish;
  logic                   fin_err;
  logic [RD_BITS*8-1:0]   fin_data;

  // Requester 1 wins when it is alone, or on a tie when 0 was served last.
  assign pick1    = req1_valid && (!req0_valid || !last_grant);
  // m_done outranks the timeout when both land on the same cycle.
  assign finish   = m_done || (cnt == CNT_LAST);
  assign fin_err  = m_done ? m_ack : 1'b1;
  // Read data arriving on the finishing cycle still reaches the requester.
  assign fin_data = m_rvalid ? m_rdata : resp_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      resp_data  <= '0;
      m_wvalid   <= 1'b0;
      m_rh_wl    <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      req0_ready <= 1'b0;
      req0_done  <= 1'b0;
      req0_err   <= 1'b0;
      req0_rdata <= '0;
      req1_ready <= 1'b0;
      req1_done  <= 1'b0;
      req1_err   <= 1'b0;
      req1_rdata <= '0;
    end else begin
      // Pulses and response outputs default low; they are raised for one cycle.
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      req0_err   <= 1'b0;
      req1_err   <= 1'b0;
      req0_rdata <= '0;
      req1_rdata <= '0;

      case (state)
        ST_IDLE: begin
          if (!m_busy && (req0_valid || req1_valid)) begin
            grant     <= pick1;
            resp_data <= '0;
            m_wvalid  <= 1'b1;
            state     <= ST_ISSUE;
            if (pick1) begin
              req1_ready <= 1'b1;
              m_rh_wl    <= req1_rh_wl;
              m_addr     <= req1_addr;
              m_wdata    <= req1_wdata;
            end else begin
              req0_ready <= 1'b1;
              m_rh_wl    <= req0_rh_wl;
              m_addr     <= req0_addr;
              m_wdata    <= req0_wdata;
            end
          end
        end

        ST_ISSUE: begin
          if (m_wready) begin
            m_wvalid <= 1'b0;
            cnt      <= '0;
            state    <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (m_rvalid) begin
            resp_data <= m_rdata;
          end
          if (finish) begin
            state <= ST_RESP;
            if (grant) begin
              req1_done  <= 1'b1;
              req1_err   <= fin_err;
              req1_rdata <= fin_data;
            end else begin
              req0_done  <= 1'b1;
              req0_err   <= fin_err;
              req0_rdata <= fin_data;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_RESP: begin
          // The done pulse is visible during this state.
          last_grant <= grant;
          state      <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb_i2c_cmd_arbiter
//   Directed and randomized checks of i2c_cmd_arbiter. Two instances share
//   every input: u_dut (long timeout) carries the functional checks, u_t16
//   (TIMEOUT_CYC = 16) carries the short-timeout check.
module tb_i2c_cmd_arbiter;

  localparam int T_LONG  = 64;
  localparam int T_SHORT = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared inputs ----------------
  logic        req0_valid, req0_rh_wl, req1_valid, req1_rh_wl;
  logic [15:0] req0_addr, req1_addr;
  logic [7:0]  req0_wdata, req1_wdata;
  logic        m_wready, m_rvalid, m_done, m_ack, m_busy;
  logic [7:0]  m_rdata;

  // ---------------- u_dut outputs ----------------
  logic        req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err;
  logic [7:0]  req0_rdata, req1_rdata;
  logic        m_wvalid, m_rh_wl;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata;

  // ---------------- u_t16 outputs ----------------
  logic        t_req0_ready, t_req0_done, t_req0_err, t_req1_ready, t_req1_done, t_req1_err;
  logic [7:0]  t_req0_rdata, t_req1_rdata;
  logic        t_m_wvalid, t_m_rh_wl;
  logic [15:0] t_m_addr;
  logic [7:0]  t_m_wdata;

  i2c_cmd_arbiter #(.WR_BITS(1), .RD_BITS(1), .TIMEOUT_CYC(T_LONG)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rh_wl(req0_rh_wl),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_rdata(req0_rdata),
    .req0_done(req0_done), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rh_wl(req1_rh_wl),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_rdata(req1_rdata),
    .req1_done(req1_done), .req1_err(req1_err),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_rh_wl(m_rh_wl), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_done(m_done),
    .m_ack(m_ack), .m_busy(m_busy)
  );

  i2c_cmd_arbiter #(.WR_BITS(1), .RD_BITS(1), .TIMEOUT_CYC(T_SHORT)) u_t16 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(t_req0_ready), .req0_rh_wl(req0_rh_wl),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_rdata(t_req0_rdata),
    .req0_done(t_req0_done), .req0_err(t_req0_err),
    .req1_valid(req1_valid), .req1_ready(t_req1_ready), .req1_rh_wl(req1_rh_wl),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_rdata(t_req1_rdata),
    .req1_done(t_req1_done), .req1_err(t_req1_err),
    .m_wvalid(t_m_wvalid), .m_wready(m_wready), .m_rh_wl(t_m_rh_wl), .m_addr(t_m_addr),
    .m_wdata(t_m_wdata), .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_done(m_done),
    .m_ack(m_ack), .m_busy(m_busy)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int last_g = 1;               // reference round-robin memory
  logic [31:0] exp_q[$];        // expected {done[1:0], err[1:0], rdata1, rdata0}

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] dut_outs();
    return 64'({req0_ready, req0_rdata, req0_done, req0_err,
                req1_ready, req1_rdata, req1_done, req1_err,
                m_wvalid, m_rh_wl, m_addr, m_wdata});
  endfunction

  function automatic logic [31:0] resp_word();
    return {12'h0, req1_done, req0_done, req1_err, req0_err, req1_rdata, req0_rdata};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    req0_valid = 0; req0_rh_wl = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_rh_wl = 0; req1_addr = 0; req1_wdata = 0;
    m_wready = 0; m_rvalid = 0; m_done = 0; m_ack = 0; m_busy = 0; m_rdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    last_g = 1;
  endtask

  // One full transfer on u_dut, starting from IDLE with requests already posted.
  task automatic xfer(input int wr_dly, input int done_dly, input bit give_rv, input int rv_at,
                      input logic [7:0] rd, input bit ack, input bit keep);
    int g;
    bit got;
    logic [24:0] exp_cmd;
    logic [7:0] exp_rd;
    // Round-robin: on a tie the requester not served last wins.
    if (req0_valid && req1_valid) g = 1 - last_g;
    else g = req1_valid ? 1 : 0;
    exp_cmd = g ? {req1_rh_wl, req1_addr, req1_wdata} : {req0_rh_wl, req0_addr, req0_wdata};
    exp_rd  = (give_rv && rv_at < done_dly) ? rd : 8'h00;
    exp_q.push_back(g ? {12'h0, 2'b10, ack, 1'b0, exp_rd, 8'h00}
                      : {12'h0, 2'b01, 1'b0, ack, 8'h00, exp_rd});

    got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) got = 1;
    end
    check("grant_seen", 64'(got), 64'd1);
    check("grant_who", 64'({req1_ready, req0_ready}), g ? 64'd2 : 64'd1);
    check("wvalid_issue", 64'(m_wvalid), 64'd1);
    check("cmd_latched", 64'({m_rh_wl, m_addr, m_wdata}), 64'(exp_cmd));

    // The accepted requester moves on; its inputs must not disturb m_*.
    if (g == 0) begin
      req0_valid = keep; req0_rh_wl = 1'($urandom);
      req0_addr = 16'($urandom); req0_wdata = 8'($urandom);
    end else begin
      req1_valid = keep; req1_rh_wl = 1'($urandom);
      req1_addr = 16'($urandom); req1_wdata = 8'($urandom);
    end

    // ISSUE stall with master noise that must be ignored outside WAIT.
    for (int i = 0; i < wr_dly; i++) begin
      m_wready = 0; m_done = 1'($urandom); m_rvalid = 1'($urandom); m_rdata = 8'($urandom);
      @(negedge clk);
      check("wvalid_hold", 64'(m_wvalid), 64'd1);
      check("cmd_hold", 64'({m_rh_wl, m_addr, m_wdata}), 64'(exp_cmd));
      check("ready_pulse", 64'({req1_ready, req0_ready}), 64'd0);
    end
    m_wready = 1;
    @(negedge clk);
    m_wready = 0; m_done = 0; m_rvalid = 0;
    check("ready_after_accept", 64'({req1_ready, req0_ready}), 64'd0);
    check("wvalid_drop", 64'(m_wvalid), 64'd0);

    // WAIT
    for (int i = 0; i < done_dly; i++) begin
      m_rvalid = give_rv && (i == rv_at);
      m_rdata  = (give_rv && i == rv_at) ? rd : 8'($urandom);
      @(negedge clk);
      check("no_early_done", 64'({req1_done, req0_done, req1_err, req0_err}), 64'd0);
    end
    m_rvalid = 0; m_done = 1; m_ack = ack; m_rdata = 8'($urandom);
    @(negedge clk);
    m_done = 0; m_ack = 0;
    check("response", 64'(resp_word()), 64'(exp_q.pop_front()));
    check("wvalid_resp", 64'(m_wvalid), 64'd0);
    last_g = g;
    @(negedge clk);
    check("done_one_cycle", 64'({req1_done, req0_done}), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int k;
    idle_inputs();
    rst_n = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", dut_outs(), 64'd0);
    rst_n = 1;
    last_g = 1;

    // Single write from requester 0, m_done 20 cycles into WAIT.
    req0_valid = 1; req0_rh_wl = 0; req0_addr = 16'h0010; req0_wdata = 8'hA5;
    xfer(0, 20, 0, 0, 8'h00, 0, 0);

    // Read from requester 1 returning 3C.
    req1_valid = 1; req1_rh_wl = 1; req1_addr = 16'h1234; req1_wdata = 8'h00;
    xfer(1, 10, 1, 3, 8'h3C, 0, 0);

    // Contention: both requesters stay valid for four transfers.
    req0_valid = 1; req0_rh_wl = 0; req0_addr = 16'hAAAA; req0_wdata = 8'h11;
    req1_valid = 1; req1_rh_wl = 1; req1_addr = 16'h5555; req1_wdata = 8'h22;
    for (int i = 0; i < 4; i++) xfer(i % 2, 3 + i, i % 2, 1, 8'h40 + 8'(i), 0, 1);
    req0_valid = 0; req1_valid = 0;

    // NACK reported as err.
    req1_valid = 1; req1_rh_wl = 0; req1_addr = 16'h0042; req1_wdata = 8'h99;
    xfer(2, 5, 0, 0, 8'h00, 1, 0);

    // m_done on the last counter value wins over the timeout.
    req0_valid = 1; req0_rh_wl = 1; req0_addr = 16'h0777; req0_wdata = 8'h01;
    xfer(0, T_LONG - 1, 1, 5, 8'hC3, 0, 0);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      int v;
      int dd;
      v = $urandom_range(1, 3);
      req0_valid = v[0]; req0_rh_wl = 1'($urandom); req0_addr = 16'($urandom); req0_wdata = 8'($urandom);
      req1_valid = v[1]; req1_rh_wl = 1'($urandom); req1_addr = 16'($urandom); req1_wdata = 8'($urandom);
      dd = $urandom_range(0, 30);
      xfer($urandom_range(0, 3), dd, 1'($urandom), $urandom_range(0, dd), 8'($urandom),
           1'($urandom), 1'($urandom));
    end
    idle_inputs();

    // Reset during WAIT aborts silently; after release, m_busy blocks grants.
    req0_valid = 1; req0_rh_wl = 1; req0_addr = 16'h0BAD; req0_wdata = 8'h5A;
    k = 0;
    while (!req0_ready && k < 40) begin @(negedge clk); k++; end
    check("abort_grant", 64'(req0_ready), 64'd1);
    m_wready = 1;
    @(negedge clk);
    m_wready = 0;
    repeat (4) @(negedge clk);
    rst_n = 0;
    #1;
    check("reset_mid_wait", dut_outs(), 64'd0);
    @(negedge clk);
    m_busy = 1;
    @(negedge clk);
    rst_n = 1;
    last_g = 1;
    m_done = 1; m_rvalid = 1; m_rdata = 8'hEE;
    @(negedge clk);
    m_done = 0; m_rvalid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("busy_no_grant", 64'({req1_ready, req0_ready, req1_done, req0_done}), 64'd0);
    end
    m_busy = 0;
    xfer(0, 4, 0, 0, 8'h00, 0, 0);

    // Timeout on the 16-cycle instance: done follows the 16th WAIT cycle.
    idle_inputs();
    do_reset();
    req0_valid = 1; req0_rh_wl = 1; req0_addr = 16'h0100; req0_wdata = 8'h00;
    k = 0;
    while (!t_req0_ready && k < 40) begin @(negedge clk); k++; end
    check("t16_grant", 64'(t_req0_ready), 64'd1);
    req0_valid = 0;
    m_wready = 1;
    @(negedge clk);
    m_wready = 0;
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (t_req0_done) break;
    end
    check("t16_timeout_cycle", 64'(k), 64'(T_SHORT));
    check("t16_timeout_resp", 64'({t_req0_done, t_req0_err, t_req0_rdata, t_req1_done, t_req1_err}),
          64'({1'b1, 1'b1, 8'h00, 1'b0, 1'b0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
